// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel button front end.
//   raw level -> 2-flop synchroniser -> debounce counter -> debounced level,
//   plus a press-classification FSM (IDLE / PRESS / LONG) that produces
//   one-cycle rise, fall, short and long pulses and a held level.
// All outputs are registered; channels are fully independent.
// Optional feature macro: AUTO_REPEAT_EN (extra btn_rise pulses every
// REPEAT_CYCLES cycles while a long press is held).
module btn_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 300_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall,
  output logic [NUM_BTN-1:0] btn_short,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    logic [DW-1:0] deb_cnt_q;
    logic          level_q;
    logic [LW-1:0] hold_cnt_q;
    state_t        state_q;
    state_t        state_d;
    logic          rise_q, fall_q, short_q, long_q, held_q;
    logic          tog;
    logic          rise_d, fall_d;
    logic          short_d, long_d, held_d;
    logic          rep_rise;
    logic          at_long;

    // A level change is accepted on the cycle after the counter has seen
    // DEBOUNCE_CYCLES consecutive mismatching cycles.
    assign tog     = (deb_cnt_q == DEB_MAX);
    assign rise_d  = tog & ~level_q;
    assign fall_d  = tog & level_q;
    assign at_long = (hold_cnt_q == LONG_MAX);

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[i];
        sync2_q <= sync1_q;
      end
    end

    // Debounce counter: counts mismatching cycles, clears on any match.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_cnt_q <= '0;
        level_q   <= 1'b0;
      end else if (tog) begin
        deb_cnt_q <= '0;
        level_q   <= ~level_q;
      end else if (sync2_q != level_q) begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end else begin
        deb_cnt_q <= '0;
      end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
    end

    // FSM next state; a release on the threshold cycle wins over LONG.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (rise_d) state_d = PRESS;
        PRESS: begin
          if (fall_d)       state_d = IDLE;
          else if (at_long) state_d = LONG;
        end
        LONG:    if (fall_d) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // FSM outputs, computed one cycle ahead and registered below.
    always_comb begin
      short_d = 1'b0;
      long_d  = 1'b0;
      held_d  = (state_d == LONG);
      if (state_q == PRESS) begin
        short_d = fall_d;
        long_d  = ~fall_d & at_long;
      end
    end

    // Hold counter: 1 in the rise cycle, saturates at LONG_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE:  hold_cnt_q <= rise_d ? LW'(1) : '0;
          PRESS: begin
            if (fall_d)        hold_cnt_q <= '0;
            else if (!at_long) hold_cnt_q <= hold_cnt_q + 1'b1;
          end
          LONG:  if (fall_d) hold_cnt_q <= '0;
          default: hold_cnt_q <= '0;
        endcase
      end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES);
    logic [RW-1:0] rep_cnt_q;

    // Repeat pulse fires REPEAT_CYCLES after the long pulse and every
    // REPEAT_CYCLES after that, suppressed by a same-cycle release.
    assign rep_rise = (state_q == LONG) & ~fall_d & (rep_cnt_q == REP_MAX);

    // Repeat counter: loads 1 with the long pulse, wraps to 1 on each repeat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_cnt_q <= '0;
      end else if (state_q == PRESS && state_d == LONG) begin
        rep_cnt_q <= RW'(1);
      end else if (state_q == LONG && !fall_d) begin
        rep_cnt_q <= (rep_cnt_q == REP_MAX) ? RW'(1) : rep_cnt_q + 1'b1;
      end else begin
        rep_cnt_q <= '0;
      end
    end
`else
    assign rep_rise = 1'b0;
`endif

    // Output pulse/level registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        rise_q  <= rise_d | rep_rise;
        fall_q  <= fall_d;
        short_q <= short_d;
        long_q  <= long_d;
        held_q  <= held_d;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_rise[i]  = rise_q;
    assign btn_fall[i]  = fall_q;
    assign btn_short[i] = short_q;
    assign btn_long[i]  = long_q;
    assign btn_held[i]  = held_q;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end button conditioning stage that sits directly upstream of the on/off control block.
- Synchronises and debounces raw board buttons.
- Produces one-cycle rise, fall, short-press and long-press pulses, plus a held level.
- The power controller consumes the long-press pulse for the 3 s shutdown hold, the rise pulses for gesture and time-adjust inputs, and the clean levels for state checks.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 1.
- LONG_CYCLES, 300_000_000, cycles of debounced press before a long press is declared (3 s); legal range >= 1.
- REPEAT_CYCLES, 20_000_000, auto-repeat period once long press is reached (used only with the optional feature).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- btn_raw  input  NUM_BTN  raw asynchronous button levels, 1 = pressed
- btn_level  output  NUM_BTN  debounced level
- btn_rise  output  NUM_BTN  one-cycle pulse on debounced press (plus repeats, see optional feature)
- btn_fall  output  NUM_BTN  one-cycle pulse on debounced release
- btn_short  output  NUM_BTN  one-cycle pulse on release occurring before long press
- btn_long  output  NUM_BTN  one-cycle pulse when press duration reaches LONG_CYCLES
- btn_held  output  NUM_BTN  high from btn_long until debounced release

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- All outputs are registered. On rst, every output, synchroniser flop, counter and FSM goes to 0/IDLE immediately.
- Channels are fully independent; simultaneous activity on any set of buttons gives per-channel timing identical to the single-button case.
- Synchroniser: 2-flop chain per bit, reset to 0.
- Debounce counter:
  - Increments each cycle the synchronised value differs from btn_level.
  - Clears to 0 on any cycle they match.
  - On reaching DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Debounce latency: a raw change held stable before edge 0 appears on btn_level in cycle DEBOUNCE_CYCLES+2. Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output activity.
- btn_rise / btn_fall are high for exactly the first cycle in which btn_level reads 1 / 0 after a toggle.
- Per-channel FSM:
  - IDLE: btn_level 0; hold counter 0. On debounced press → PRESS.
  - PRESS: hold counter increments each cycle, starting at 1 in the btn_rise cycle.
    - Counter reaches LONG_CYCLES → LONG. btn_long pulses in that cycle; btn_held goes high from the same cycle.
    - Debounced release first → IDLE. btn_short pulses in the same cycle as btn_fall.
  - LONG: hold counter frozen. Debounced release → IDLE; btn_fall pulses, btn_held drops in that cycle, no btn_short.
- Hold counter width is $clog2(LONG_CYCLES+1) and saturates; no wrap-around.
- Release and the LONG_CYCLES threshold in the same cycle: release wins. btn_short pulses, btn_long does not.
- Reset mid-press: all state is lost. A button still held when rst deasserts is treated as a new press: btn_rise occurs DEBOUNCE_CYCLES+2 cycles after deassertion, and the long timer restarts.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: while in LONG, a repeat counter generates an extra one-cycle btn_rise every REPEAT_CYCLES cycles. The first repeat comes REPEAT_CYCLES cycles after the btn_long cycle. The counter clears on release or reset; btn_level is unaffected.
- Not defined: btn_rise pulses only on debounced edges, REPEAT_CYCLES is unused, and no repeat logic is synthesised.

Test Plan:
- Params D=4, L=20, R=5 throughout.
- Clean press: btn_raw[0]=1 from cycle 0 for 12 cycles, then 0 → btn_level[0] high cycles 6..17; btn_rise[0] at 6; btn_fall[0] and btn_short[0] at 18; no btn_long.
- Bounce: btn_raw[1] toggles 1,1,1,0 repeatedly for 40 cycles → all outputs for channel 1 stay 0.
- Long hold: btn_raw[2]=1 for 40 cycles → btn_rise at 6, btn_long at 26, btn_held 26..45, btn_fall at 46, no btn_short.
- Reset mid-hold: hold btn_raw[0]; assert rst at cycle 15 for 3 cycles → outputs 0 asynchronously; btn_rise again 6 cycles after deassertion; btn_long 20 cycles after that.
- Simultaneous: btn_raw[3] and btn_raw[4] rise together at cycle 0 → both channels produce btn_rise at 6; independent release timing is respected.
- AUTO_REPEAT_EN: hold btn_raw[0] for 40 cycles → btn_rise at 6, 31, 36, 41; btn_long at 26; no repeat after release; without the macro, only the pulse at 6.
